// File: rtl/frame_pkg.sv
// Shared types and header constants for the line packetizer.
// Holds the packet sync bytes, the frame/transmit state encodings and the pixel layout.
package frame_pkg;

   localparam logic [7:0] SYNC0   = 8'hA5;
   localparam logic [7:0] SYNC1   = 8'h5A;
   localparam int         HDR_LEN = 8;

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_e;

   typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_PAY, TX_LAST} tx_e;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;

endpackage

// File: rtl/line_bank.sv
// Two line banks in one simple dual-port RAM; the address MSB selects the bank.
// The read port is registered and holds its last value until the next read.
module line_bank
   import frame_pkg::*;
#(
   parameter int ADDR_W = 11
)(
   input  logic              clk,
   input  logic              wr_en_i,
   input  logic [ADDR_W:0]   wr_addr_i,
   input  pixel_t            wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W:0]   rd_addr_i,
   output pixel_t            rd_data_o
);

   pixel_t mem_q [2**(ADDR_W+1)];
   pixel_t rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/line_packetizer.sv
// Captures one triggered camera frame line by line into ping-pong banks and
// emits each stored line as an 8-byte header plus RGB payload on a valid/ready byte stream.
module line_packetizer
   import frame_pkg::*;
#(
   parameter int H_ACT  = 1280,
   parameter int ADDR_W = 11
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        trig,
   input  logic        vsync,
   input  logic        href,
   input  logic [7:0]  r,
   input  logic [7:0]  g,
   input  logic [7:0]  b,
   output logic [7:0]  o_data,
   output logic        o_valid,
   input  logic        o_ready,
   output logic        o_last,
   output logic        busy,
   output logic [15:0] drop_cnt
);

   state_e      state_q;
   logic        vsync_q;
   logic        in_line_q;
   logic        drop_q;
   logic        wr_sel_q;
   logic        rd_sel_q;
   logic [15:0] wr_cnt_q;
   logic [1:0]  bank_full_q;
   logic [1:0]  bank_full_d;
   logic [15:0] bank_len_q  [2];
   logic [15:0] bank_line_q [2];
   logic [15:0] line_no_q;
   logic [15:0] drop_cnt_q;
   logic [7:0]  frame_id_q;

   tx_e         tx_q;
   logic [2:0]  hdr_idx_q;
   logic [1:0]  byte_sel_q;
   logic [15:0] pix_idx_q;
   logic [7:0]  pix_g_q;
   logic [7:0]  pix_b_q;
   logic [7:0]  o_data_q;
   logic        o_valid_q;
   logic        o_last_q;

   logic              vsync_rise;
   logic              href_act;
   logic              line_start;
   logic              line_end;
   logic              drop_now;
   logic [15:0]       cnt_cur;
   logic              wr_en;
   pixel_t            wr_pix;
   logic              bank_free;
   logic              ld;
   logic              hdr_end;
   logic [15:0]       pix_next;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_off;
   pixel_t            rd_pix;
   logic [15:0]       cur_len;
   logic [15:0]       cur_line;
   logic [7:0]        hdr_byte;

   // Pixels only count in CAPTURE and never while vsync is high; that also
   // closes a line still open at the frame-ending vsync edge.
   assign vsync_rise = vsync && !vsync_q;
   assign href_act   = (state_q == CAPTURE) && href && !vsync;
   assign line_start = href_act && !in_line_q;
   assign line_end   = in_line_q && !href_act;
   assign drop_now   = line_start ? bank_full_q[wr_sel_q] : drop_q;
   assign cnt_cur    = line_start ? 16'd0 : wr_cnt_q;
   assign wr_en      = href_act && !drop_now && (cnt_cur < 16'(H_ACT));
   assign wr_pix     = {r, g, b};

   assign bank_free  = (tx_q == TX_LAST) && o_valid_q && o_ready;
   assign ld         = !o_valid_q || o_ready;
   assign hdr_end    = (tx_q == TX_HDR) && (hdr_idx_q == 3'(HDR_LEN - 1));
   assign pix_next   = pix_idx_q + 16'd1;
   // Pixel 0 is fetched with header byte 7; pixel k+1 is fetched while the R byte of pixel k loads.
   assign rd_en      = ld && (hdr_end || ((tx_q == TX_PAY) && (byte_sel_q == 2'd0)));
   assign rd_off     = hdr_end ? {ADDR_W{1'b0}} : pix_next[ADDR_W-1:0];
   assign cur_len    = bank_len_q[rd_sel_q];
   assign cur_line   = bank_line_q[rd_sel_q];

   line_bank #(.ADDR_W(ADDR_W)) u_bank (
      .clk       (clk),
      .wr_en_i   (wr_en),
      .wr_addr_i ({wr_sel_q, cnt_cur[ADDR_W-1:0]}),
      .wr_data_i (wr_pix),
      .rd_en_i   (rd_en),
      .rd_addr_i ({rd_sel_q, rd_off}),
      .rd_data_o (rd_pix)
   );

   always_comb begin
      bank_full_d = bank_full_q;
      if (bank_free) begin
         bank_full_d[rd_sel_q] = 1'b0;
      end
      if (line_end && !drop_q) begin
         bank_full_d[wr_sel_q] = 1'b1;
      end
   end

   always_comb begin
      hdr_byte = 8'h00;
      case (hdr_idx_q)
         3'd1:    hdr_byte = SYNC1;
         3'd2:    hdr_byte = frame_id_q;
         3'd3:    hdr_byte = cur_line[15:8];
         3'd4:    hdr_byte = cur_line[7:0];
         3'd5:    hdr_byte = cur_len[15:8];
         3'd6:    hdr_byte = cur_len[7:0];
         default: hdr_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         vsync_q        <= 1'b0;
         in_line_q      <= 1'b0;
         drop_q         <= 1'b0;
         wr_sel_q       <= 1'b0;
         rd_sel_q       <= 1'b0;
         wr_cnt_q       <= '0;
         bank_full_q    <= '0;
         bank_len_q[0]  <= '0;
         bank_len_q[1]  <= '0;
         bank_line_q[0] <= '0;
         bank_line_q[1] <= '0;
         line_no_q      <= '0;
         drop_cnt_q     <= '0;
         frame_id_q     <= '0;
      end else begin
         vsync_q     <= vsync;
         bank_full_q <= bank_full_d;
         if (bank_free) begin
            rd_sel_q <= ~rd_sel_q;
         end
         if (line_start) begin
            in_line_q <= 1'b1;
            drop_q    <= drop_now;
            if (drop_now && (drop_cnt_q != 16'hFFFF)) begin
               drop_cnt_q <= drop_cnt_q + 16'd1;
            end
         end
         if (wr_en) begin
            wr_cnt_q <= cnt_cur + 16'd1;
         end else if (line_start) begin
            wr_cnt_q <= '0;
         end
         if (line_end) begin
            in_line_q <= 1'b0;
            line_no_q <= line_no_q + 16'd1;
            if (!drop_q) begin
               bank_len_q[wr_sel_q]  <= wr_cnt_q;
               bank_line_q[wr_sel_q] <= line_no_q;
               wr_sel_q              <= ~wr_sel_q;
            end
         end
         case (state_q)
            IDLE: begin
               if (trig) begin
                  state_q <= ARMED;
               end
            end
            ARMED: begin
               if (vsync_rise) begin
                  state_q    <= CAPTURE;
                  line_no_q  <= '0;
                  drop_cnt_q <= '0;
               end
            end
            CAPTURE: begin
               if (vsync_rise) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if ((bank_full_q == 2'b00) && !in_line_q && (tx_q == TX_IDLE)) begin
                  state_q    <= IDLE;
                  frame_id_q <= frame_id_q + 8'd1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_q       <= TX_IDLE;
         hdr_idx_q  <= '0;
         byte_sel_q <= '0;
         pix_idx_q  <= '0;
         pix_g_q    <= '0;
         pix_b_q    <= '0;
         o_data_q   <= '0;
         o_valid_q  <= 1'b0;
         o_last_q   <= 1'b0;
      end else begin
         case (tx_q)
            TX_IDLE: begin
               if (bank_full_q[rd_sel_q]) begin
                  o_data_q  <= SYNC0;
                  o_valid_q <= 1'b1;
                  o_last_q  <= 1'b0;
                  hdr_idx_q <= 3'd1;
                  tx_q      <= TX_HDR;
               end
            end
            TX_HDR: begin
               if (ld) begin
                  o_data_q  <= hdr_byte;
                  hdr_idx_q <= hdr_idx_q + 3'd1;
                  if (hdr_end) begin
                     pix_idx_q  <= '0;
                     byte_sel_q <= 2'd0;
                     if (cur_len == 16'd0) begin
                        o_last_q <= 1'b1;
                        tx_q     <= TX_LAST;
                     end else begin
                        tx_q <= TX_PAY;
                     end
                  end
               end
            end
            TX_PAY: begin
               if (ld) begin
                  case (byte_sel_q)
                     2'd0: begin
                        o_data_q   <= rd_pix.r;
                        pix_g_q    <= rd_pix.g;
                        pix_b_q    <= rd_pix.b;
                        byte_sel_q <= 2'd1;
                     end
                     2'd1: begin
                        o_data_q   <= pix_g_q;
                        byte_sel_q <= 2'd2;
                     end
                     default: begin
                        o_data_q   <= pix_b_q;
                        byte_sel_q <= 2'd0;
                        pix_idx_q  <= pix_next;
                        if (pix_next == cur_len) begin
                           o_last_q <= 1'b1;
                           tx_q     <= TX_LAST;
                        end
                     end
                  endcase
               end
            end
            TX_LAST: begin
               if (o_ready) begin
                  o_valid_q <= 1'b0;
                  o_last_q  <= 1'b0;
                  tx_q      <= TX_IDLE;
               end
            end
         endcase
      end
   end

   assign o_data   = o_data_q;
   assign o_valid  = o_valid_q;
   assign o_last   = o_last_q;
   assign busy     = (state_q != IDLE);
   assign drop_cnt = drop_cnt_q;

endmodule
